// File: rtl/counter_seq_checker.sv
// counter_seq_checker: checks that a sampled free-running counter steps by +1 mod 2^WIDTH
//   clk       in   single clock, all state updates on posedge
//   rst       in   synchronous active-high reset
//   q_in      in   [WIDTH-1:0] counter value from the upstream counter
//   q_valid   in   q_in qualifier; low means the cycle is ignored and state holds
//   locked    out  high while in LOCKED
//   err       out  one-cycle pulse on a sequence mismatch while LOCKED
//   err_cnt   out  [CNT_W-1:0] saturating count of err pulses
//   wrap_cnt  out  [CNT_W-1:0] saturating count of legal max->0 steps seen while LOCKED
// Build option: define COUNT_CHK_HOLD_EN to also accept q_in == prev (upstream clock enable).
module counter_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_valid,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
    localparam logic [3:0] LOCK_N = LOCK_CNT[3:0];
    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       step_cnt_q, step_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [WIDTH-1:0] prev_inc;
    logic             step_ok;
    logic             hold_ok;
    assign prev_inc = prev_q + 1'b1;
    assign step_ok  = q_in == prev_inc;
`ifdef COUNT_CHK_HOLD_EN
    assign hold_ok = q_in == prev_q;
`else
    assign hold_ok = 1'b0;
`endif
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        step_cnt_d = step_cnt_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        if (q_valid) begin
            prev_d = q_in;
            case (state_q)
                IDLE: begin
                    step_cnt_d = '0;
                    state_d    = ACQUIRE;
                end
                ACQUIRE: begin
                    // a held value (hold build) keeps the run going without advancing it
                    if (step_ok) begin
                        step_cnt_d = step_cnt_q + 4'd1;
                        state_d    = (step_cnt_d == LOCK_N) ? LOCKED : ACQUIRE;
                    end else if (!hold_ok) begin
                        step_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (!(step_ok || hold_ok)) begin
                        err_d      = 1'b1;
                        err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
                        step_cnt_d = '0;
                        state_d    = ACQUIRE;
                    end else if (step_ok && (&prev_q)) begin
                        wrap_cnt_d = (&wrap_cnt_q) ? wrap_cnt_q : wrap_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            step_cnt_q <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            step_cnt_q <= step_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end
    assign locked   = state_q == LOCKED;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign wrap_cnt = wrap_cnt_q;
endmodule

// File: tb/tb_counter_seq_checker.sv
// tb_counter_seq_checker: randomized and directed bench for counter_seq_checker against a behavioural model
module tb_counter_seq_checker;
    localparam int WIDTH    = 8;
    localparam int LOCK_CNT = 4;
    localparam int CNT_W    = 8;
    localparam int QMAX     = (1 << WIDTH) - 1;
    localparam int CMAX     = (1 << CNT_W) - 1;
`ifdef COUNT_CHK_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             q_valid = 1'b0;
    logic [WIDTH-1:0] q_in = '0;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] wrap_cnt;
    int n_chk  = 0;
    int n_fail = 0;
    bit run    = 1'b0;
    int cur    = 0;
    // model: mode 0 = idle, 1 = acquiring, 2 = locked
    int m_mode = 0;
    int m_prev = 0;
    int m_steps = 0;
    int m_errc = 0;
    int m_wrapc = 0;
    bit m_err = 1'b0;
    int m_nxt;
    int m_qi;

    always #5 clk = ~clk;

    counter_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .q_valid(q_valid),
        .locked(locked), .err(err), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_err = 1'b0;
        m_qi  = int'(q_in);
        m_nxt = (m_prev + 1) % (QMAX + 1);
        if (rst) begin
            m_mode = 0; m_prev = 0; m_steps = 0; m_errc = 0; m_wrapc = 0;
        end else if (q_valid) begin
            if (m_mode == 0) begin
                m_steps = 0;
                m_mode  = 1;
            end else if (m_mode == 1) begin
                if (m_qi == m_nxt) begin
                    m_steps++;
                    if (m_steps == LOCK_CNT) m_mode = 2;
                end else if (!(HOLD && m_qi == m_prev)) begin
                    m_steps = 0;
                end
            end else begin
                if (m_qi == m_nxt) begin
                    if (m_qi == 0 && m_wrapc < CMAX) m_wrapc++;
                end else if (!(HOLD && m_qi == m_prev)) begin
                    m_err = 1'b1;
                    if (m_errc < CMAX) m_errc++;
                    m_steps = 0;
                    m_mode  = 1;
                end
            end
            m_prev = m_qi;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("cmp_locked", locked, m_mode == 2);
            chk("cmp_err", err, m_err);
            chk("cmp_err_cnt", err_cnt, m_errc);
            chk("cmp_wrap_cnt", wrap_cnt, m_wrapc);
        end
    end

    task automatic step(input int v, input bit valid);
        q_in    = v[WIDTH-1:0];
        q_valid = valid;
        if (valid) cur = v & QMAX;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int v;
        bit vld;
        repeat (5) @(posedge clk);
        #1;
        run = 1'b1;
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_wrap_cnt", wrap_cnt, 0);
        rst = 1'b0;
        for (int i = 0; i <= 9; i++) begin
            step(i, 1'b1);
            if (i == 3) chk("t1_unlocked_at_3", locked, 0);
            if (i == 4) chk("t1_locked_at_4", locked, 1);
        end
        chk("t1_err_cnt", err_cnt, 0);
        for (int i = 10; i <= 255; i++) step(i, 1'b1);
        chk("t2_wrap_before", wrap_cnt, 0);
        step(0, 1'b1);
        chk("t2_wrap_after", wrap_cnt, 1);
        chk("t2_no_err", err, 0);
        for (int i = 1; i <= 20; i++) step(i, 1'b1);
        step(40, 1'b1);
        chk("t3_err", err, 1);
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_unlocked", locked, 0);
        step(41, 1'b1);
        chk("t3_err_pulse", err, 0);
        step(42, 1'b1);
        step(43, 1'b1);
        chk("t3_not_yet", locked, 0);
        step(44, 1'b1);
        chk("t3_relock", locked, 1);
        repeat (10) step(int'($urandom_range(0, QMAX)), 1'b0);
        chk("t4_hold_locked", locked, 1);
        step(cur + 1, 1'b1);
        chk("t4_resume_err", err, 0);
        chk("t4_resume_locked", locked, 1);
        while (cur != 6) step(cur + 1, 1'b1);
        step(7, 1'b1);
        chk("hold_locked", locked, 1);
        step(7, 1'b1);
        chk("hold_err", err, HOLD ? 0 : 1);
        chk("hold_err_cnt", err_cnt, HOLD ? 1 : 2);
        repeat (LOCK_CNT) step(cur + 1, 1'b1);
        chk("t5_locked_before", locked, 1);
        rst = 1'b1;
        step(cur + 1, 1'b1);
        rst = 1'b0;
        chk("t5_locked", locked, 0);
        chk("t5_err_cnt", err_cnt, 0);
        chk("t5_wrap_cnt", wrap_cnt, 0);
        for (int i = 100; i <= 103; i++) step(i, 1'b1);
        chk("t5_not_yet", locked, 0);
        step(104, 1'b1);
        chk("t5_relock", locked, 1);
        repeat (300) begin
            step(cur + 2 + int'($urandom_range(0, 200)), 1'b1);
            repeat (LOCK_CNT) step(cur + 1, 1'b1);
        end
        chk("t6_err_sat", err_cnt, CMAX);
        chk("t6_locked", locked, 1);
        rst = 1'b1;
        step(250, 1'b1);
        rst = 1'b0;
        repeat (3000) begin
            k   = int'($urandom_range(0, 9));
            vld = $urandom_range(0, 3) != 0;
            v   = (k < 7) ? cur + 1 : (k == 7) ? cur : (k == 8) ? int'($urandom_range(0, QMAX)) : cur + 2;
            rst = $urandom_range(0, 199) == 0;
            step(v, vld);
            rst = 1'b0;
        end
        @(negedge clk);
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
